// File: rtl/sha256_padder.sv
// rtl/sha256_padder.sv - packs a 32-bit word message stream into padded 512-bit SHA-256 blocks
module sha256_padder #(
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid_i,
  input  logic [31:0]  in_data_i,
  input  logic         in_last_i,
  input  logic [2:0]   in_nbytes_i,
  output logic         in_ready_o,
  input  logic         eng_ready_i,
  output logic         eng_start_o,
  output logic [511:0] eng_vec_o,
  output logic         eng_last_o,
  output logic         msg_done_o,
  output logic [63:0]  bitlen_o
);

  typedef enum logic [2:0] {
    S_FILL,
    S_PAD,
    S_SEND,
    S_WAIT,
    S_EXTRA
  } state_t;

  state_t           state;
  logic [31:0]      blk [16];
  logic [3:0]       widx;
  logic [3:0]       widx_p1;
  logic [LEN_W-1:0] len;
  logic [63:0]      len64;
  logic             extra_pend;  // another block (length only) follows this one
  logic             defer80;     // the 0x80 marker spilled into the next block
  logic             seen_low;    // engine went busy after our start pulse

  logic             accept;
  logic [2:0]       n_eff;
  logic [31:0]      last_word;
  logic [4:0]       q;
  logic [5:0]       len_add;
  logic [LEN_W-1:0] len_next;
  logic             blk_rdy;

  // Buffer words are presented to the engine unregistered, word 0 at the top.
  always_comb begin
    eng_vec_o = '0;
    for (int i = 0; i < 16; i++) begin
      eng_vec_o[511-32*i -: 32] = blk[i];
    end
  end

  // Zero-extend the running length into the 64-bit length field.
  always_comb begin
    len64 = '0;
    len64[LEN_W-1:0] = len;
  end

  // Decode of the incoming word: marker placement, length step and block readiness.
  always_comb begin
    accept  = (state == S_FILL) && in_ready_o && in_valid_i;
    n_eff   = (in_nbytes_i >= 3'd4) ? 3'd4 : in_nbytes_i;
    widx_p1 = widx + 4'd1;
    case (n_eff)
      3'd0:    last_word = 32'h8000_0000;
      3'd1:    last_word = {in_data_i[31:24], 24'h80_0000};
      3'd2:    last_word = {in_data_i[31:16], 16'h8000};
      3'd3:    last_word = {in_data_i[31:8], 8'h80};
      default: last_word = in_data_i;
    endcase
    // q is the word index holding 0x80; 16 means it lands in the next block.
    q        = {1'b0, widx} + ((n_eff == 3'd4) ? 5'd1 : 5'd0);
    len_add  = in_last_i ? {n_eff, 3'b000} : 6'd32;
    len_next = len + LEN_W'(len_add);
    blk_rdy  = (state == S_PAD) || (state == S_EXTRA) || (state == S_SEND) ||
               (accept && !in_last_i && (widx == 4'd15)) ||
               (accept && in_last_i && (q > 5'd13));
  end

  // Main sequencer: fill, pad, hand off to the engine and wait for it to finish.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= S_FILL;
      widx        <= '0;
      len         <= '0;
      extra_pend  <= 1'b0;
      defer80     <= 1'b0;
      seen_low    <= 1'b0;
      in_ready_o  <= 1'b0;
      eng_start_o <= 1'b0;
      eng_last_o  <= 1'b0;
      msg_done_o  <= 1'b0;
      bitlen_o    <= '0;
      for (int i = 0; i < 16; i++) begin
        blk[i] <= '0;
      end
    end else begin
      eng_start_o <= 1'b0;
      msg_done_o  <= 1'b0;
      case (state)
        S_FILL: begin
          in_ready_o <= 1'b1;
          if (accept) begin
            len <= len_next;
            if (!in_last_i) begin
              blk[widx] <= in_data_i;
              widx      <= widx_p1;
              if (widx == 4'd15) begin
                in_ready_o <= 1'b0;
                eng_last_o <= 1'b0;
              end
            end else begin
              blk[widx] <= last_word;
              if ((n_eff == 3'd4) && (widx != 4'd15)) begin
                blk[widx_p1] <= 32'h8000_0000;
              end
              in_ready_o <= 1'b0;
              if (q <= 5'd13) begin
                state <= S_PAD;
              end else begin
                extra_pend <= 1'b1;
                defer80    <= (q == 5'd16);
                eng_last_o <= 1'b0;
              end
            end
          end
        end
        S_PAD: begin
          blk[14]    <= len64[63:32];
          blk[15]    <= len64[31:0];
          eng_last_o <= 1'b1;
        end
        S_EXTRA: begin
          if (defer80) begin
            blk[0] <= 32'h8000_0000;
          end
          defer80    <= 1'b0;
          extra_pend <= 1'b0;
          blk[14]    <= len64[63:32];
          blk[15]    <= len64[31:0];
          eng_last_o <= 1'b1;
        end
        S_SEND: begin
        end
        S_WAIT: begin
          if (!eng_ready_i) begin
            seen_low <= 1'b1;
          end else if (seen_low) begin
            seen_low <= 1'b0;
            widx     <= '0;
            for (int i = 0; i < 16; i++) begin
              blk[i] <= '0;
            end
            if (eng_last_o) begin
              msg_done_o <= 1'b1;
              bitlen_o   <= len64;
              len        <= '0;
              eng_last_o <= 1'b0;
            end
            if (extra_pend) begin
              state <= S_EXTRA;
            end else begin
              state      <= S_FILL;
              in_ready_o <= 1'b1;
            end
          end
        end
        default: state <= S_FILL;
      endcase
      // A completed block launches at once when the engine is idle, else parks in SEND.
      if (blk_rdy) begin
        if (eng_ready_i) begin
          eng_start_o <= 1'b1;
          seen_low    <= 1'b0;
          state       <= S_WAIT;
        end else begin
          state <= S_SEND;
        end
      end
    end
  end

endmodule

// File: tb/tb_sha256_padder.sv
// tb/tb_sha256_padder.sv - directed self-checking bench for sha256_padder
module tb_sha256_padder;

  logic         clk = 1'b0;
  logic         rstn;
  logic         in_valid;
  logic [31:0]  in_data;
  logic         in_last;
  logic [2:0]   in_nbytes;
  logic         in_ready;
  logic         eng_ready;
  logic         eng_start;
  logic [511:0] eng_vec;
  logic         eng_last;
  logic         msg_done;
  logic [63:0]  bitlen;

  always #5 clk = ~clk;

  sha256_padder #(.LEN_W(64)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .in_last_i   (in_last),
    .in_nbytes_i (in_nbytes),
    .in_ready_o  (in_ready),
    .eng_ready_i (eng_ready),
    .eng_start_o (eng_start),
    .eng_vec_o   (eng_vec),
    .eng_last_o  (eng_last),
    .msg_done_o  (msg_done),
    .bitlen_o    (bitlen)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Engine stand-in: busy for busy_len cycles after each start, captures blocks.
  int           busy_cnt  = 0;
  int           busy_len  = 6;
  bit           hold      = 1'b0;
  int           cyc       = 0;
  int           done_cnt  = 0;
  int           start_cnt = 0;
  logic [511:0] vec_q[$];
  logic         last_q[$];
  int           scyc_q[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (eng_start) begin
      busy_cnt  <= busy_len;
      start_cnt <= start_cnt + 1;
      vec_q.push_back(eng_vec);
      last_q.push_back(eng_last);
      scyc_q.push_back(cyc);
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end
    if (msg_done) done_cnt <= done_cnt + 1;
  end

  assign eng_ready = !hold && (busy_cnt == 0);

  logic [7:0] mb [0:127];
  logic [7:0] pb [0:127];
  int         exp_nblk;
  int         accept_cyc;

  task automatic put_word(input logic [31:0] d, input bit last, input logic [2:0] n);
    int t;
    in_valid  = 1'b1;
    in_data   = d;
    in_last   = last;
    in_nbytes = n;
    t = 0;
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) check("in_ready_timeout", 64'd0, 64'd1);
    accept_cyc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Bytes past the message end are junk so that masking is exercised.
  task automatic send_msg(input int nbytes, input bit use_ovr, input logic [2:0] ovr);
    int nw;
    logic [2:0] nl;
    logic [7:0] b [4];
    if (nbytes == 0) begin
      nw = 1; nl = 3'd0;
    end else if (nbytes % 4 == 0) begin
      nw = nbytes / 4; nl = 3'd4;
    end else begin
      nw = nbytes / 4 + 1; nl = 3'(nbytes % 4);
    end
    if (use_ovr) nl = ovr;
    for (int w = 0; w < nw; w++) begin
      for (int k = 0; k < 4; k++) b[k] = (4*w+k < nbytes) ? mb[4*w+k] : 8'hEE;
      put_word({b[0], b[1], b[2], b[3]}, (w == nw-1), (w == nw-1) ? nl : 3'd1);
    end
  endtask

  task automatic build_expected(input int nbytes);
    logic [63:0] bl;
    int          l;
    bl = 64'(nbytes) * 64'd8;
    l  = ((nbytes + 8) / 64 + 1) * 64;
    exp_nblk = l / 64;
    for (int k = 0; k < 128; k++) pb[k] = 8'h00;
    for (int k = 0; k < nbytes; k++) pb[k] = mb[k];
    pb[nbytes] = 8'h80;
    for (int k = 0; k < 8; k++) pb[l-8+k] = bl[63-8*k -: 8];
  endtask

  task automatic run_msg(input string name, input int nbytes, input bit use_ovr, input logic [2:0] ovr);
    int d0;
    int t;
    logic [31:0] ew;
    logic [511:0] v;
    vec_q.delete(); last_q.delete(); scyc_q.delete();
    d0 = done_cnt;
    build_expected(nbytes);
    send_msg(nbytes, use_ovr, ovr);
    t = 0;
    while (done_cnt == d0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (10) @(negedge clk);
    check({name, "_done"}, 64'(done_cnt - d0), 64'd1);
    check({name, "_nblk"}, 64'(vec_q.size()), 64'(exp_nblk));
    check({name, "_bitlen"}, bitlen, 64'(nbytes) * 64'd8);
    for (int bi = 0; bi < vec_q.size() && bi < exp_nblk; bi++) begin
      v = vec_q[bi];
      check($sformatf("%s_b%0d_last", name, bi), 64'(last_q[bi]), 64'(bi == exp_nblk-1));
      for (int w = 0; w < 16; w++) begin
        ew = {pb[64*bi+4*w], pb[64*bi+4*w+1], pb[64*bi+4*w+2], pb[64*bi+4*w+3]};
        check($sformatf("%s_b%0d_w%0d", name, bi, w), 64'(v[511-32*w -: 32]), 64'(ew));
      end
    end
  endtask

  function automatic logic [31:0] blk_word(input int bi, input int w);
    logic [511:0] v;
    v = vec_q[bi];
    return v[511-32*w -: 32];
  endfunction

  task automatic fill_seq();
    for (int k = 0; k < 128; k++) mb[k] = 8'(k + 1);
  endtask

  initial begin
    int s0;
    int d0;
    int t;
    rstn = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_nbytes = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_start", 64'(eng_start), 64'd0);
    check("rst_vec", 64'(eng_vec != '0), 64'd0);
    check("rst_last", 64'(eng_last), 64'd0);
    check("rst_done", 64'(msg_done), 64'd0);
    check("rst_bitlen", bitlen, 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // "abc"
    mb[0] = 8'h61; mb[1] = 8'h62; mb[2] = 8'h63;
    run_msg("abc", 3, 1'b0, 3'd0);
    if (vec_q.size() >= 1) begin
      check("abc_w0", 64'(blk_word(0, 0)), 64'h61626380);
      check("abc_w15", 64'(blk_word(0, 15)), 64'h18);
      check("abc_latency", 64'(scyc_q[0] - accept_cyc), 64'd2);
    end

    run_msg("empty", 0, 1'b0, 3'd0);
    if (vec_q.size() >= 1) check("empty_w0", 64'(blk_word(0, 0)), 64'h80000000);

    fill_seq();
    run_msg("m55", 55, 1'b0, 3'd0);
    if (vec_q.size() >= 1) begin
      check("m55_w13", 64'(blk_word(0, 13)), 64'h35363780);
      check("m55_w15", 64'(blk_word(0, 15)), 64'h1B8);
    end

    run_msg("m56", 56, 1'b0, 3'd0);
    if (vec_q.size() >= 2) begin
      check("m56_b0_w14", 64'(blk_word(0, 14)), 64'h80000000);
      check("m56_b1_w15", 64'(blk_word(1, 15)), 64'h1C0);
    end

    run_msg("m64", 64, 1'b0, 3'd0);
    if (vec_q.size() >= 2) begin
      check("m64_b1_w0", 64'(blk_word(1, 0)), 64'h80000000);
      check("m64_b1_w15", 64'(blk_word(1, 15)), 64'h200);
      check("m64_latency", 64'(scyc_q[0] - accept_cyc), 64'd1);
    end

    run_msg("m8", 8, 1'b0, 3'd0);
    run_msg("n7_as_4", 4, 1'b1, 3'd7);

    // Backpressure in SEND
    mb[0] = 8'h61; mb[1] = 8'h62; mb[2] = 8'h63;
    hold = 1'b1;
    s0 = start_cnt;
    d0 = done_cnt;
    send_msg(3, 1'b0, 3'd0);
    repeat (50) @(negedge clk);
    check("bp_no_start", 64'(start_cnt - s0), 64'd0);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    check("bp_vec_w0", 64'(eng_vec[511:480]), 64'h61626380);
    check("bp_vec_w15", 64'(eng_vec[31:0]), 64'h18);
    hold = 1'b0;
    t = 0;
    while (done_cnt == d0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("bp_done", 64'(done_cnt - d0), 64'd1);
    check("bp_start", 64'(start_cnt - s0), 64'd1);

    // Reset while the engine is working on the final block
    busy_len = 30;
    s0 = start_cnt;
    send_msg(3, 1'b0, 3'd0);
    t = 0;
    while (start_cnt == s0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("rw_started", 64'(start_cnt - s0), 64'd1);
    repeat (5) @(negedge clk);
    d0 = done_cnt;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    check("rw_in_ready", 64'(in_ready), 64'd0);
    check("rw_start", 64'(eng_start), 64'd0);
    check("rw_vec", 64'(eng_vec != '0), 64'd0);
    check("rw_last", 64'(eng_last), 64'd0);
    check("rw_bitlen", bitlen, 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (60) @(negedge clk);
    check("rw_no_done", 64'(done_cnt - d0), 64'd0);
    check("rw_no_start", 64'(start_cnt - s0), 64'd1);
    busy_len = 6;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sha256_padder.md
Name: sha256_padder

Overview:
Message front end for sha256_engine. It accepts a byte-oriented message as a stream of 32-bit big-endian words and packs them into 512-bit blocks. It applies the FIPS 180-4 padding: a 0x80 byte, zero fill, then the 64-bit message bit length. Each block is handed to the engine over its ready/start/vec interface, and the final block is flagged via the engine's sha256_fifo_empty input.

Parameters:
LEN_W, 64, width of the message bit-length counter; value is zero-extended into the 64-bit length field; wraps modulo 2^LEN_W.

Ports:
clk  in  1  system clock
rstn  in  1  reset, synchronous, active-low
in_valid_i  in  1  input word valid
in_data_i  in  32  message word, first byte in [31:24]
in_last_i  in  1  word is the last of the message
in_nbytes_i  in  3  valid bytes in the last word, 0..4; ignored (treated as 4) when in_last_i=0
in_ready_o  out  1  padder accepts a word this cycle
eng_ready_i  in  1  engine ready_o
eng_start_o  out  1  one-cycle start pulse to the engine start_i
eng_vec_o  out  512  block to the engine vec_i; word 0 in [511:480]
eng_last_o  out  1  to the engine sha256_fifo_empty; 1 while the final block of a message is outstanding
msg_done_o  out  1  one-cycle pulse when the engine finishes the final block
bitlen_o  out  64  bit length of the last completed message

Behaviour:
- Reset: all outputs 0, buffer cleared to zero, widx=0, length counter=0, state FILL. Reset mid-block or mid-engine-run discards everything. No pulse is emitted.
- Buffer: 16x32-bit words, driven directly onto eng_vec_o. It is cleared to zero in the cycle a block is released (WAIT→FILL/EXTRA), so zero fill needs no cycles.
- FILL: in_ready_o=1. A word is accepted when in_valid_i=1.
  - Non-last word: write buf[widx]; length += 32; widx++.
  - When widx was 15 (buffer now full): go to SEND, eng_last_o=0.
- Last word, with n=in_nbytes_i:
  - n=1..3: write the masked data with 0x80 in byte n; the remaining bytes are 0.
  - n=4: data goes to buf[widx] and 0x80 goes to buf[widx+1][31:24]; if widx=15, the 0x80 goes to the next block.
  - n=0: only 0x80 is written, at buf[widx][31:24].
  - In all cases length += 8n.
  - Let q be the index of the word holding 0x80. If q≤13: go to PAD. Otherwise (0x80 in word 14/15 or deferred): go to SEND with eng_last_o=0, then EXTRA.
- PAD (1 cycle): buf[14]={length[63:32]}, buf[15]=length[31:0] (using the final length); eng_last_o=1; go to SEND.
- EXTRA (1 cycle): the buffer is already zero. Write the deferred 0x80 into buf[0][31:24] if pending, then the length into words 14/15; eng_last_o=1; go to SEND.
- SEND: in_ready_o=0. Wait for eng_ready_i=1, then assert eng_start_o for exactly 1 cycle and go to WAIT.
- WAIT: in_ready_o=0. eng_vec_o and eng_last_o are held stable. Done is detected only after eng_ready_i has been sampled 0 at least once after the start pulse, followed by eng_ready_i=1.
  - On done, if eng_last_o=1: pulse msg_done_o, load bitlen_o, clear length, clear eng_last_o.
  - If an extra block is pending, go to EXTRA; else go to FILL with widx=0.
- Latency: 16th word accepted in cycle t gives eng_start_o in t+1 if eng_ready_i=1. Last word with q≤13 gives start in t+2.
- in_valid_i outside FILL is ignored; data is not consumed.
- Simultaneous eng_ready_i=1 and the block becoming ready: start fires on the first SEND cycle.
- in_nbytes_i values 5..7 on a last word are treated as 4.
- The length counter wraps silently.

Test Plan:
- "abc" (one word 0x61626300, last, n=3) → single start. eng_vec_o = 0x61626380, 13×0, 0x00000000, 0x00000018; eng_last_o=1. Engine hash ba7816bf…f20015ad. msg_done_o pulses once; bitlen_o=24.
- Empty message (n=0, last) → one block 0x80000000, zeros, length 0. Hash e3b0c442…7852b855.
- 55-byte message (13 full words + last n=3) → one block; word13 low byte=0x80; word15=0x000001B8.
- 56-byte message → two blocks. Block1 word14=0x80000000, eng_last_o=0; block2 all zero except word15=0x000001C0, eng_last_o=1. msg_done_o only after block2.
- 64-byte message (16 words, last n=4) → block1 = data; block2 word0=0x80000000, word15=0x00000200.
- Backpressure: hold eng_ready_i=0 for 50 cycles in SEND → no start, in_ready_o=0, vec stable. Assert rstn=0 in WAIT → all outputs 0 next cycle and no msg_done_o.
